// File: rtl/magic_nmi_sched_pkg.sv
// Shared types and constants for the magic NMI scheduler.
package magic_nmi_sched_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_MAGIC = 2'd1,
        CAUSE_PAUSE = 2'd2,
        CAUSE_EXT   = 2'd3
    } nmi_cause_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        ASSERT,
        SERVICE,
        HOLDOFF
    } nmi_sched_state_t;

    localparam logic [15:0] NMI_VECTOR = 16'h0066;

endpackage

// File: rtl/magic_nmi_sched_btn.sv
// Button debouncer: two-flop synchroniser, then the level must hold for
// 2^DEBOUNCE_W cycles before the stable output follows it.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_W = 16
) (
    input  logic clk28,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise
);

    logic [1:0]            sync;
    logic [DEBOUNCE_W-1:0] cnt;

    always_ff @(posedge clk28) begin
        if (rst) begin
            sync   <= '0;
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rise <= 1'b0;
            // Counting runs only while the input disagrees with the stable level.
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == '1) begin
                cnt    <= '0;
                stable <= sync[1];
                rise   <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/magic_nmi_sched.sv
// Magic NMI scheduler: debounced button requests, fixed-priority arbitration,
// frame-aligned NMI with acknowledge/timeout/holdoff. Optional MAGIC_NMI_EXT_EN
// enables ext_req as a third, lowest-priority source.
import magic_nmi_sched_pkg::*;

module magic_nmi_sched #(
    parameter int unsigned DEBOUNCE_W     = 16,
    parameter int unsigned TIMEOUT_FRAMES = 4,
    parameter int unsigned HOLDOFF_FRAMES = 2
) (
    input  logic        clk28,
    input  logic        rst,
    input  logic        magic_button,
    input  logic        pause_button,
    input  logic        ext_req,
    input  logic        n_int,
    input  logic        n_int_next,
    input  logic        m1,
    input  logic        mreq,
    input  logic [15:0] a,
    input  logic        magic_mode,
    input  logic        cause_rd,
    output logic        n_nmi,
    output logic [1:0]  nmi_cause,
    output logic        busy
);

    if (TIMEOUT_FRAMES < 1 || TIMEOUT_FRAMES > 7) begin : g_bad_timeout
        $error("TIMEOUT_FRAMES must be in 1..7");
    end
    if (HOLDOFF_FRAMES < 1 || HOLDOFF_FRAMES > 7) begin : g_bad_holdoff
        $error("HOLDOFF_FRAMES must be in 1..7");
    end

    localparam logic [2:0] TMO_LAST = 3'(TIMEOUT_FRAMES - 1);
    localparam logic [2:0] HLD_LAST = 3'(HOLDOFF_FRAMES - 1);

    nmi_sched_state_t state_q, state_d;
    nmi_cause_t       cause_q, win_cause;
    logic [2:0]       frame_cnt;
    logic             frame_strobe, ack, any_pend;
    logic             magic_level, magic_rise, pause_level, pause_rise;
    logic             pend_magic, pend_pause, pend_ext;
    logic             mm_seen, n_nmi_q, n_nmi_d, serve, abandon;
    logic             unused_levels;

    assign frame_strobe  = n_int & ~n_int_next;
    assign ack           = m1 & mreq & (a == NMI_VECTOR);
    assign unused_levels = magic_level ^ pause_level;

    btn_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_magic_db (
        .clk28 (clk28),
        .rst   (rst),
        .raw   (magic_button),
        .stable(magic_level),
        .rise  (magic_rise)
    );

    btn_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_pause_db (
        .clk28 (clk28),
        .rst   (rst),
        .raw   (pause_button),
        .stable(pause_level),
        .rise  (pause_rise)
    );

    // A new request in the serve cycle wins over the clear.
    always_ff @(posedge clk28) begin
        if (rst) begin
            pend_magic <= 1'b0;
            pend_pause <= 1'b0;
        end else begin
            if (serve && win_cause == CAUSE_MAGIC) pend_magic <= 1'b0;
            if (magic_rise)                        pend_magic <= 1'b1;
            if (serve && win_cause == CAUSE_PAUSE) pend_pause <= 1'b0;
            if (pause_rise)                        pend_pause <= 1'b1;
        end
    end

`ifdef MAGIC_NMI_EXT_EN
    always_ff @(posedge clk28) begin
        if (rst) begin
            pend_ext <= 1'b0;
        end else begin
            if (serve && win_cause == CAUSE_EXT) pend_ext <= 1'b0;
            if (ext_req)                         pend_ext <= 1'b1;
        end
    end
`else
    logic unused_ext;
    assign pend_ext   = 1'b0;
    assign unused_ext = ext_req;
`endif

    assign any_pend = pend_magic | pend_pause | pend_ext;

    always_comb begin
        win_cause = CAUSE_NONE;
        if (pend_magic)      win_cause = CAUSE_MAGIC;
        else if (pend_pause) win_cause = CAUSE_PAUSE;
        else if (pend_ext)   win_cause = CAUSE_EXT;
    end

    always_ff @(posedge clk28) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (any_pend && !magic_mode) state_d = WAIT_FRAME;
            WAIT_FRAME: begin
                if (magic_mode)        state_d = IDLE;
                else if (frame_strobe) state_d = ASSERT;
            end
            ASSERT: begin
                if (ack)                                     state_d = SERVICE;
                else if (frame_strobe && frame_cnt == TMO_LAST) state_d = IDLE;
            end
            // Leave once the session has come and gone, or if it never started.
            SERVICE: begin
                if (mm_seen && !magic_mode)
                    state_d = HOLDOFF;
                else if (!mm_seen && !magic_mode && frame_strobe && frame_cnt == TMO_LAST)
                    state_d = HOLDOFF;
            end
            HOLDOFF:    if (frame_strobe && frame_cnt == HLD_LAST) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        serve   = (state_q == WAIT_FRAME) && (state_d == ASSERT);
        abandon = (state_q == ASSERT) && (state_d == IDLE);
        n_nmi_d = (state_d != ASSERT);
    end

    // Frame counter restarts on every state change and saturates at 7.
    always_ff @(posedge clk28) begin
        if (rst) begin
            n_nmi_q   <= 1'b1;
            cause_q   <= CAUSE_NONE;
            frame_cnt <= '0;
            mm_seen   <= 1'b0;
        end else begin
            n_nmi_q <= n_nmi_d;
            if (serve)                   cause_q <= win_cause;
            else if (abandon || cause_rd) cause_q <= CAUSE_NONE;
            if (state_d != state_q)                  frame_cnt <= '0;
            else if (frame_strobe && frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
            if (state_d != state_q)                     mm_seen <= 1'b0;
            else if (state_q == SERVICE && magic_mode)  mm_seen <= 1'b1;
        end
    end

    assign n_nmi     = n_nmi_q;
    assign nmi_cause = cause_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_magic_nmi_sched.sv
// Self-checking bench for magic_nmi_sched; expected causes are queued when a
// request is stimulated and checked when n_nmi falls.
import magic_nmi_sched_pkg::*;

module tb_magic_nmi_sched;

    localparam int FRAME = 128;
    localparam int DBW   = 6;

    logic        clk28 = 1'b0;
    logic        rst, magic_button, pause_button, ext_req;
    logic        n_int, n_int_next, m1, mreq, magic_mode, cause_rd;
    logic [15:0] a;
    logic        n_nmi, busy;
    logic [1:0]  nmi_cause;

    int          checks = 0;
    int          errors = 0;
    int          falls  = 0;
    logic [1:0]  exp_q[$];

    magic_nmi_sched #(
        .DEBOUNCE_W    (DBW),
        .TIMEOUT_FRAMES(4),
        .HOLDOFF_FRAMES(2)
    ) dut (
        .clk28       (clk28),
        .rst         (rst),
        .magic_button(magic_button),
        .pause_button(pause_button),
        .ext_req     (ext_req),
        .n_int       (n_int),
        .n_int_next  (n_int_next),
        .m1          (m1),
        .mreq        (mreq),
        .a           (a),
        .magic_mode  (magic_mode),
        .cause_rd    (cause_rd),
        .n_nmi       (n_nmi),
        .nmi_cause   (nmi_cause),
        .busy        (busy)
    );

    initial forever #5 clk28 = ~clk28;

    // Frame interrupt generator: low for 8 cycles out of every FRAME.
    initial begin
        int fcnt;
        fcnt       = 0;
        n_int      = 1'b1;
        n_int_next = 1'b1;
        forever begin
            @(posedge clk28);
            #2;
            n_int      = n_int_next;
            fcnt       = (fcnt + 1) % FRAME;
            n_int_next = !(fcnt < 8);
        end
    end

    // Scoreboard: every NMI must start one cycle after a frame strobe and
    // carry the oldest outstanding expected cause.
    initial begin
        logic prev_nmi, strobe_at_edge;
        logic [1:0] e;
        prev_nmi = 1'b1;
        forever begin
            @(posedge clk28);
            strobe_at_edge = n_int && !n_int_next;
            #1;
            if (prev_nmi === 1'b1 && n_nmi === 1'b0) begin
                falls++;
                checks++;
                if (!strobe_at_edge) begin
                    errors++;
                    $display("FAIL nmi_latency got no_strobe want strobe_prev_cycle");
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL nmi_unexpected got cause %0d want no_nmi", nmi_cause);
                end else begin
                    e = exp_q.pop_front();
                    if (nmi_cause !== e) begin
                        errors++;
                        $display("FAIL nmi_cause got %0d want %0d", nmi_cause, e);
                    end
                end
            end
            prev_nmi = n_nmi;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk28);
    endtask

    // Returns at the negedge just after the clock edge that sampled a strobe.
    task automatic wait_strobe();
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk28);
            if (n_int && !n_int_next) break;
        end
        @(negedge clk28);
    endtask

    task automatic wait_fall(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk28);
            if (falls > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic fetch(input logic [15:0] addr);
        m1 = 1'b1; mreq = 1'b1; a = addr;
        cyc(1);
        m1 = 1'b0; mreq = 1'b0; a = 16'h0000;
    endtask

    task automatic end_session();
        magic_mode = 1'b1;
        cyc(5);
        magic_mode = 1'b0;
        wait_strobe();
        wait_strobe();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(3);
        checks++;
        if (n_nmi !== 1'b1) begin errors++; $display("FAIL reset_n_nmi got %b want 1", n_nmi); end
        checks++;
        if (nmi_cause !== 2'd0) begin errors++; $display("FAIL reset_cause got %0d want 0", nmi_cause); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic test_debounce();
        int base;
        bit ok;
        base = falls;
        for (int i = 0; i < 20; i++) begin
            magic_button = ~magic_button;
            cyc(10);
        end
        checks++;
        if (falls != base) begin errors++; $display("FAIL bounce_no_nmi got %0d want %0d", falls, base); end
        exp_q.push_back(2'd1);
        magic_button = 1'b1;
        wait_fall(base, 3 * FRAME, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL debounce_nmi got none want nmi"); end
        cyc(5);
        checks++;
        if (falls != base + 1) begin errors++; $display("FAIL debounce_once got %0d want %0d", falls - base, 1); end
        checks++;
        if (nmi_cause !== 2'd1) begin errors++; $display("FAIL debounce_cause got %0d want 1", nmi_cause); end
    endtask

    task automatic test_ack();
        fetch(16'h0067);
        checks++;
        if (n_nmi !== 1'b0) begin errors++; $display("FAIL ack_wrong_addr got %b want 0", n_nmi); end
        fetch(16'h0066);
        checks++;
        if (n_nmi !== 1'b1) begin errors++; $display("FAIL ack_release got %b want 1", n_nmi); end
        checks++;
        if (dut.state_q !== SERVICE) begin errors++; $display("FAIL ack_state got %0d want %0d", dut.state_q, SERVICE); end
        magic_button = 1'b0;
        end_session();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL holdoff_idle got %b want 0", busy); end
    endtask

    task automatic test_priority();
        int base;
        bit ok;
        wait_strobe();
        base = falls;
        exp_q.push_back(2'd2);
`ifdef MAGIC_NMI_EXT_EN
        exp_q.push_back(2'd3);
`endif
        pause_button = 1'b1;
        ext_req = 1'b1;
        cyc(1);
        ext_req = 1'b0;
        wait_fall(base, 2 * FRAME, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL prio_first got none want nmi"); end
        checks++;
        if (nmi_cause !== 2'd2) begin errors++; $display("FAIL prio_cause got %0d want 2", nmi_cause); end
        pause_button = 1'b0;
        fetch(16'h0066);
        end_session();
        checks++;
        if (falls != base + 1) begin errors++; $display("FAIL prio_holdoff got %0d want %0d", falls - base, 1); end
`ifdef MAGIC_NMI_EXT_EN
        wait_fall(base + 1, 2 * FRAME, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL prio_second got none want nmi"); end
        checks++;
        if (nmi_cause !== 2'd3) begin errors++; $display("FAIL prio_ext_cause got %0d want 3", nmi_cause); end
        fetch(16'h0066);
        end_session();
`else
        wait_strobe();
        wait_strobe();
        checks++;
        if (falls != base + 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ext_ignored got falls %0d busy %b want falls 1 busy 0", falls - base, busy);
        end
`endif
    endtask

    task automatic test_blocking();
        int base;
        bit ok;
        base = falls;
        exp_q.push_back(2'd1);
        magic_button = 1'b1;
        wait_fall(base, 3 * FRAME, ok);
        magic_button = 1'b0;
        fetch(16'h0066);
        magic_mode = 1'b1;
        pause_button = 1'b1;
        cyc(FRAME + 20);
        checks++;
        if (falls != base + 1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL block_session got falls %0d busy %b want falls 1 busy 1", falls - base, busy);
        end
        exp_q.push_back(2'd2);
        pause_button = 1'b0;
        magic_mode = 1'b0;
        wait_strobe();
        wait_strobe();
        checks++;
        if (falls != base + 1) begin errors++; $display("FAIL block_holdoff got %0d want %0d", falls - base, 1); end
        wait_fall(base + 1, 2 * FRAME, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL block_after got none want nmi"); end
        checks++;
        if (nmi_cause !== 2'd2) begin errors++; $display("FAIL block_cause got %0d want 2", nmi_cause); end
        cause_rd = 1'b1;
        cyc(1);
        cause_rd = 1'b0;
        checks++;
        if (nmi_cause !== 2'd0) begin errors++; $display("FAIL cause_rd got %0d want 0", nmi_cause); end
        fetch(16'h0066);
        end_session();
    endtask

    task automatic test_timeout();
        int base;
        bit ok;
        base = falls;
        exp_q.push_back(2'd1);
        magic_button = 1'b1;
        wait_fall(base, 3 * FRAME, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL tmo_nmi got none want nmi"); end
        magic_button = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            wait_strobe();
            checks++;
            if (n_nmi !== 1'b0) begin errors++; $display("FAIL tmo_hold_%0d got %b want 0", k, n_nmi); end
        end
        wait_strobe();
        checks++;
        if (n_nmi !== 1'b1 || nmi_cause !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_abandon got n_nmi %b cause %0d busy %b want 1 0 0", n_nmi, nmi_cause, busy);
        end
    endtask

    task automatic test_reset_in_assert();
        int base;
        bit ok;
        base = falls;
        exp_q.push_back(2'd1);
        magic_button = 1'b1;
        wait_fall(base, 3 * FRAME, ok);
        magic_button = 1'b0;
        pause_button = 1'b1;
        ext_req = 1'b1;
        cyc(1);
        ext_req = 1'b0;
        cyc(DBW * 12);
        checks++;
        if (dut.state_q !== ASSERT) begin errors++; $display("FAIL rst_pre_state got %0d want %0d", dut.state_q, ASSERT); end
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        pause_button = 1'b0;
        checks++;
        if (n_nmi !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_release got n_nmi %b busy %b want 1 0", n_nmi, busy);
        end
        checks++;
        if ({dut.pend_magic, dut.pend_pause, dut.pend_ext} !== 3'b000) begin
            errors++;
            $display("FAIL rst_pending got %b want 000", {dut.pend_magic, dut.pend_pause, dut.pend_ext});
        end
        wait_strobe();
        wait_strobe();
        wait_strobe();
        checks++;
        if (falls != base + 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_quiet got falls %0d busy %b want falls 1 busy 0", falls - base, busy);
        end
    endtask

    initial begin
        rst = 1'b1; magic_button = 1'b0; pause_button = 1'b0; ext_req = 1'b0;
        m1 = 1'b0; mreq = 1'b0; a = 16'h0000; magic_mode = 1'b0; cause_rd = 1'b0;
        test_reset();
        test_debounce();
        test_ack();
        test_priority();
        test_blocking();
        test_timeout();
        test_reset_in_assert();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain got %0d want 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
